// File: rtl/bullet_hit_gen.sv
// bullet_hit_gen: one bullet per tank plus the shot_hit1/shot_hit2 pulse emitter.
// Everything advances once per frame_clk edge. Bullets fire on a key-press edge,
// fly in the direction latched at fire time, and despawn on a hit or at the
// playfield border. Hits become single-frame pulses spaced by HIT_GAP low frames
// so the game state machine never misses one.
module bullet_hit_gen #(
    parameter int          SCREEN_W   = 640,
    parameter int          SCREEN_H   = 480,
    parameter int          TANK_W     = 32,
    parameter int          TANK_H     = 32,
    parameter int          BULLET_SZ  = 4,
    parameter int          BULLET_SPD = 4,
    parameter int          HIT_GAP    = 2,
    parameter logic [7:0]  FIRE1_KEY  = 8'h2C,
    parameter logic [7:0]  FIRE2_KEY  = 8'h28
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic [31:0] keycode,
    input  logic        game_over,
    input  logic [9:0]  tank1_x,
    input  logic [9:0]  tank1_y,
    input  logic [1:0]  tank1_dir,
    input  logic [9:0]  tank2_x,
    input  logic [9:0]  tank2_y,
    input  logic [1:0]  tank2_dir,
    output logic [9:0]  bullet1_x,
    output logic [9:0]  bullet1_y,
    output logic        bullet1_on,
    output logic [9:0]  bullet2_x,
    output logic [9:0]  bullet2_y,
    output logic        bullet2_on,
    output logic        shot_hit1,
    output logic        shot_hit2
);

    localparam int CNT_W = (HIT_GAP < 1) ? 1 : $clog2(HIT_GAP + 1);

    // 12-bit working width: coordinate (max 1023) plus box size never overflows.
    localparam logic [11:0] SW12  = 12'(SCREEN_W);
    localparam logic [11:0] SH12  = 12'(SCREEN_H);
    localparam logic [11:0] TW12  = 12'(TANK_W);
    localparam logic [11:0] TH12  = 12'(TANK_H);
    localparam logic [11:0] SZ12  = 12'(BULLET_SZ);
    localparam logic [11:0] SPD12 = 12'(BULLET_SPD);

    localparam logic [9:0] SPD10    = 10'(BULLET_SPD);
    localparam logic [9:0] SPAWN_DX = 10'(TANK_W / 2 - BULLET_SZ / 2);
    localparam logic [9:0] SPAWN_DY = 10'(TANK_H / 2 - BULLET_SZ / 2);

    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(HIT_GAP);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    typedef enum logic {
        IDLE = 1'b0,
        FLY  = 1'b1
    } bullet_state_t;

    // A key counts as pressed when any of the four keycode bytes carries it.
    function automatic logic key_down(input logic [31:0] kc, input logic [7:0] key);
        return (kc[7:0] == key) || (kc[15:8] == key) ||
               (kc[23:16] == key) || (kc[31:24] == key);
    endfunction

    // Strict AABB test: boxes that only share an edge do not collide.
    function automatic logic boxes_overlap(input logic [9:0] bx, input logic [9:0] by,
                                           input logic [9:0] tx, input logic [9:0] ty);
        logic [11:0] bxw, byw, txw, tyw;
        bxw = {2'b00, bx};
        byw = {2'b00, by};
        txw = {2'b00, tx};
        tyw = {2'b00, ty};
        return (bxw < txw + TW12) && (bxw + SZ12 > txw) &&
               (byw < tyw + TH12) && (byw + SZ12 > tyw);
    endfunction

    // True when the next step would carry the bullet outside the playfield.
    function automatic logic leaves_field(input logic [9:0] x, input logic [9:0] y,
                                          input logic [1:0] dir);
        logic [11:0] xw, yw;
        logic        out;
        xw  = {2'b00, x};
        yw  = {2'b00, y};
        out = 1'b0;
        case (dir)
            2'd0:    out = (yw < SPD12);
            2'd1:    out = (xw + SPD12 + SZ12 > SW12);
            2'd2:    out = (yw + SPD12 + SZ12 > SH12);
            default: out = (xw < SPD12);
        endcase
        return out;
    endfunction

    bullet_state_t b1_state, b1_state_next;
    bullet_state_t b2_state, b2_state_next;
    logic [1:0]    b1_dir, b1_dir_next;
    logic [1:0]    b2_dir, b2_dir_next;
    logic [9:0]    b1_x_next, b1_y_next;
    logic [9:0]    b2_x_next, b2_y_next;

    logic          key1_now, key2_now;
    logic          key1_prev, key2_prev;
    logic          fire1_edge, fire2_edge;

    logic          col1, col2;
    logic          pend1, pend2, pend1_next, pend2_next;
    logic [CNT_W-1:0] gap_cnt, gap_cnt_next;
    logic          emit1, emit2;

    assign key1_now   = key_down(keycode, FIRE1_KEY);
    assign key2_now   = key_down(keycode, FIRE2_KEY);
    assign fire1_edge = key1_now && !key1_prev;
    assign fire2_edge = key2_now && !key2_prev;

    // Key history keeps tracking during game_over so a key held across it cannot fire later.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            key1_prev <= 1'b0;
            key2_prev <= 1'b0;
        end else begin
            key1_prev <= key1_now;
            key2_prev <= key2_now;
        end
    end

    // Bullet 1 next state: spawn on fire edge, then hit tank2, despawn at border, or step.
    always_comb begin
        b1_state_next = b1_state;
        b1_dir_next   = b1_dir;
        b1_x_next     = bullet1_x;
        b1_y_next     = bullet1_y;
        col2          = 1'b0;
        if (game_over) begin
            b1_state_next = IDLE;
        end else begin
            unique case (b1_state)
                IDLE: begin
                    if (fire1_edge) begin
                        b1_state_next = FLY;
                        b1_x_next     = tank1_x + SPAWN_DX;
                        b1_y_next     = tank1_y + SPAWN_DY;
                        b1_dir_next   = tank1_dir;
                    end
                end
                FLY: begin
                    if (boxes_overlap(bullet1_x, bullet1_y, tank2_x, tank2_y)) begin
                        b1_state_next = IDLE;
                        col2          = 1'b1;
                    end else if (leaves_field(bullet1_x, bullet1_y, b1_dir)) begin
                        b1_state_next = IDLE;
                    end else begin
                        case (b1_dir)
                            2'd0:    b1_y_next = bullet1_y - SPD10;
                            2'd1:    b1_x_next = bullet1_x + SPD10;
                            2'd2:    b1_y_next = bullet1_y + SPD10;
                            default: b1_x_next = bullet1_x - SPD10;
                        endcase
                    end
                end
                default: b1_state_next = IDLE;
            endcase
        end
    end

    // Bullet 2 next state: mirror of bullet 1, tested against tank1.
    always_comb begin
        b2_state_next = b2_state;
        b2_dir_next   = b2_dir;
        b2_x_next     = bullet2_x;
        b2_y_next     = bullet2_y;
        col1          = 1'b0;
        if (game_over) begin
            b2_state_next = IDLE;
        end else begin
            unique case (b2_state)
                IDLE: begin
                    if (fire2_edge) begin
                        b2_state_next = FLY;
                        b2_x_next     = tank2_x + SPAWN_DX;
                        b2_y_next     = tank2_y + SPAWN_DY;
                        b2_dir_next   = tank2_dir;
                    end
                end
                FLY: begin
                    if (boxes_overlap(bullet2_x, bullet2_y, tank1_x, tank1_y)) begin
                        b2_state_next = IDLE;
                        col1          = 1'b1;
                    end else if (leaves_field(bullet2_x, bullet2_y, b2_dir)) begin
                        b2_state_next = IDLE;
                    end else begin
                        case (b2_dir)
                            2'd0:    b2_y_next = bullet2_y - SPD10;
                            2'd1:    b2_x_next = bullet2_x + SPD10;
                            2'd2:    b2_y_next = bullet2_y + SPD10;
                            default: b2_x_next = bullet2_x - SPD10;
                        endcase
                    end
                end
                default: b2_state_next = IDLE;
            endcase
        end
    end

    // Bullet registers; positions hold while idle so the last location stays visible.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            b1_state   <= IDLE;
            b2_state   <= IDLE;
            b1_dir     <= 2'd0;
            b2_dir     <= 2'd0;
            bullet1_x  <= 10'd0;
            bullet1_y  <= 10'd0;
            bullet2_x  <= 10'd0;
            bullet2_y  <= 10'd0;
            bullet1_on <= 1'b0;
            bullet2_on <= 1'b0;
        end else begin
            b1_state   <= b1_state_next;
            b2_state   <= b2_state_next;
            b1_dir     <= b1_dir_next;
            b2_dir     <= b2_dir_next;
            bullet1_x  <= b1_x_next;
            bullet1_y  <= b1_y_next;
            bullet2_x  <= b2_x_next;
            bullet2_y  <= b2_y_next;
            bullet1_on <= (b1_state_next == FLY);
            bullet2_on <= (b2_state_next == FLY);
        end
    end

    // Hit emitter: release at most one pending hit per frame, tank1 first, then hold
    // the line low for HIT_GAP frames. New collisions join the pending set afterwards.
    always_comb begin
        emit1        = 1'b0;
        emit2        = 1'b0;
        pend1_next   = pend1;
        pend2_next   = pend2;
        gap_cnt_next = gap_cnt;
        if (game_over) begin
            pend1_next   = 1'b0;
            pend2_next   = 1'b0;
            gap_cnt_next = CNT_ZERO;
        end else begin
            if (gap_cnt == CNT_ZERO) begin
                if (pend1) begin
                    emit1 = 1'b1;
                end else if (pend2) begin
                    emit2 = 1'b1;
                end
            end
            if (emit1 || emit2) begin
                gap_cnt_next = GAP_LOAD;
            end else if (gap_cnt != CNT_ZERO) begin
                gap_cnt_next = gap_cnt - CNT_ONE;
            end
            pend1_next = (pend1 && !emit1) || col1;
            pend2_next = (pend2 && !emit2) || col2;
        end
    end

    // Emitter registers and the registered hit pulses.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            pend1     <= 1'b0;
            pend2     <= 1'b0;
            gap_cnt   <= CNT_ZERO;
            shot_hit1 <= 1'b0;
            shot_hit2 <= 1'b0;
        end else begin
            pend1     <= pend1_next;
            pend2     <= pend2_next;
            gap_cnt   <= gap_cnt_next;
            shot_hit1 <= emit1;
            shot_hit2 <= emit2;
        end
    end

endmodule

// File: tb/tb_bullet_hit_gen.sv
// Bench for bullet_hit_gen: directed scenarios followed by randomized frames,
// every frame compared against a frame-level behavioural model of bullets and hits.
module tb_bullet_hit_gen;

    localparam int SW      = 640;
    localparam int SH      = 480;
    localparam int TW      = 32;
    localparam int TH      = 32;
    localparam int SZ      = 4;
    localparam int SPD     = 4;
    localparam int HIT_GAP = 2;
    localparam logic [7:0] K1 = 8'h2C;
    localparam logic [7:0] K2 = 8'h28;

    logic        frame_clk = 1'b0;
    logic        Reset;
    logic [31:0] keycode;
    logic        game_over;
    logic [9:0]  tank1_x, tank1_y, tank2_x, tank2_y;
    logic [1:0]  tank1_dir, tank2_dir;
    logic [9:0]  bullet1_x, bullet1_y, bullet2_x, bullet2_y;
    logic        bullet1_on, bullet2_on, shot_hit1, shot_hit2;

    always #5 frame_clk = ~frame_clk;

    bullet_hit_gen #(
        .SCREEN_W(SW), .SCREEN_H(SH), .TANK_W(TW), .TANK_H(TH),
        .BULLET_SZ(SZ), .BULLET_SPD(SPD), .HIT_GAP(HIT_GAP),
        .FIRE1_KEY(K1), .FIRE2_KEY(K2)
    ) dut (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .game_over(game_over),
        .tank1_x(tank1_x), .tank1_y(tank1_y), .tank1_dir(tank1_dir),
        .tank2_x(tank2_x), .tank2_y(tank2_y), .tank2_dir(tank2_dir),
        .bullet1_x(bullet1_x), .bullet1_y(bullet1_y), .bullet1_on(bullet1_on),
        .bullet2_x(bullet2_x), .bullet2_y(bullet2_y), .bullet2_on(bullet2_on),
        .shot_hit1(shot_hit1), .shot_hit2(shot_hit2)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: index 0 = tank1 / bullet1, index 1 = tank2 / bullet2.
    // m_pend[i] means tank i+1 has been hit and its pulse is still owed.
    int m_on[2], m_x[2], m_y[2], m_dir[2], m_hit[2];
    bit m_prev[2], m_pend[2];
    int frame_no   = 0;
    int last_pulse = -1000;

    int hit1_cnt, hit2_cnt, hit1_at, hit2_at;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (frame %0d)", tag, obs, exp, frame_no);
        end
    endtask

    function automatic bit key_in(input logic [31:0] kc, input logic [7:0] k);
        bit hit = 0;
        for (int b = 0; b < 4; b++) if (kc[8*b +: 8] == k) hit = 1;
        return hit;
    endfunction

    // One frame of the game rules, applied to the inputs seen at this edge.
    task automatic model_step();
        int tx[2], ty[2], td[2];
        bit pressed[2];
        int nx, ny, opp;
        tx[0] = int'(tank1_x); ty[0] = int'(tank1_y); td[0] = int'(tank1_dir);
        tx[1] = int'(tank2_x); ty[1] = int'(tank2_y); td[1] = int'(tank2_dir);
        if (Reset) begin
            for (int i = 0; i < 2; i++) begin
                m_on[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0;
                m_hit[i] = 0; m_prev[i] = 0; m_pend[i] = 0;
            end
            last_pulse = -1000;
            frame_no++;
            return;
        end
        pressed[0] = key_in(keycode, K1);
        pressed[1] = key_in(keycode, K2);
        m_hit[0] = 0;
        m_hit[1] = 0;
        // Pulses owed from earlier frames go out first, one per frame, spaced by HIT_GAP.
        if (game_over) begin
            m_pend[0] = 0; m_pend[1] = 0;
            last_pulse = -1000;
        end else if (frame_no - last_pulse > HIT_GAP) begin
            if (m_pend[0]) begin
                m_hit[0] = 1; m_pend[0] = 0; last_pulse = frame_no;
            end else if (m_pend[1]) begin
                m_hit[1] = 1; m_pend[1] = 0; last_pulse = frame_no;
            end
        end
        for (int i = 0; i < 2; i++) begin
            opp = 1 - i;
            if (game_over) begin
                m_on[i] = 0;
            end else if (m_on[i] == 0) begin
                if (pressed[i] && !m_prev[i]) begin
                    m_on[i]  = 1;
                    m_x[i]   = (tx[i] + TW / 2 - SZ / 2) % 1024;
                    m_y[i]   = (ty[i] + TH / 2 - SZ / 2) % 1024;
                    m_dir[i] = td[i];
                end
            end else if (m_x[i] < tx[opp] + TW && m_x[i] + SZ > tx[opp] &&
                         m_y[i] < ty[opp] + TH && m_y[i] + SZ > ty[opp]) begin
                m_on[i] = 0;
                m_pend[opp] = 1;
            end else begin
                nx = m_x[i]; ny = m_y[i];
                case (m_dir[i])
                    0: ny = ny - SPD;
                    1: nx = nx + SPD;
                    2: ny = ny + SPD;
                    default: nx = nx - SPD;
                endcase
                if (nx < 0 || ny < 0 || nx + SZ > SW || ny + SZ > SH) m_on[i] = 0;
                else begin m_x[i] = nx; m_y[i] = ny; end
            end
        end
        m_prev[0] = pressed[0];
        m_prev[1] = pressed[1];
        frame_no++;
    endtask

    task automatic tick();
        @(posedge frame_clk);
        model_step();
        #1;
        check_val("bullet1_on", bullet1_on, m_on[0]);
        check_val("bullet2_on", bullet2_on, m_on[1]);
        check_val("bullet1_x", bullet1_x, m_x[0]);
        check_val("bullet1_y", bullet1_y, m_y[0]);
        check_val("bullet2_x", bullet2_x, m_x[1]);
        check_val("bullet2_y", bullet2_y, m_y[1]);
        check_val("shot_hit1", shot_hit1, m_hit[0]);
        check_val("shot_hit2", shot_hit2, m_hit[1]);
        if (shot_hit1) begin hit1_cnt++; hit1_at = frame_no; end
        if (shot_hit2) begin hit2_cnt++; hit2_at = frame_no; end
    endtask

    task automatic set_tanks(input int x1, input int y1, input int d1,
                             input int x2, input int y2, input int d2);
        tank1_x = 10'(x1); tank1_y = 10'(y1); tank1_dir = 2'(d1);
        tank2_x = 10'(x2); tank2_y = 10'(y2); tank2_dir = 2'(d2);
    endtask

    task automatic do_reset();
        Reset = 1'b1; keycode = '0; game_over = 1'b0;
        tick();
        Reset = 1'b0;
        hit1_cnt = 0; hit2_cnt = 0; hit1_at = 0; hit2_at = 0;
    endtask

    initial begin
        int t1x, t1y, t2x, t2y, go_left;
        bit found;
        logic [31:0] kc;

        set_tanks(0, 0, 0, 0, 0, 0);
        do_reset();
        check_val("rst_on1", bullet1_on, 0);
        check_val("rst_hit1", shot_hit1, 0);
        check_val("rst_x2", bullet2_x, 0);

        // Straight shot right into tank2.
        set_tanks(100, 200, 1, 300, 200, 0);
        keycode = 32'h0000_002C;
        tick();
        check_val("t1_spawn_on", bullet1_on, 1);
        check_val("t1_spawn_x", bullet1_x, 114);
        check_val("t1_spawn_y", bullet1_y, 214);
        keycode = '0;
        tick();
        check_val("t1_step_x", bullet1_x, 118);
        for (int i = 0; i < 60; i++) tick();
        check_val("t1_hit2_count", hit2_cnt, 1);
        check_val("t1_hit1_count", hit1_cnt, 0);

        // Shot off the right edge: despawn, no pulse.
        do_reset();
        set_tanks(600, 100, 1, 100, 400, 0);
        keycode = 32'h2C00_0000;
        tick();
        keycode = '0;
        for (int i = 0; i < 10; i++) tick();
        check_val("t2_on", bullet1_on, 0);
        check_val("t2_hits", hit1_cnt + hit2_cnt, 0);

        // Both tanks hit in the same frame: pulses separated by HIT_GAP low frames.
        do_reset();
        set_tanks(100, 200, 1, 300, 200, 3);
        keycode = 32'h0000_282C;
        tick();
        keycode = '0;
        for (int i = 0; i < 60; i++) tick();
        check_val("t3_cnt1", hit1_cnt, 1);
        check_val("t3_cnt2", hit2_cnt, 1);
        check_val("t3_spacing", hit2_at - hit1_at, HIT_GAP + 1);

        // Held key fires exactly once; re-fire needs release and press.
        do_reset();
        set_tanks(300, 300, 0, 500, 50, 0);
        keycode = 32'h002C_0000;
        for (int i = 0; i < 50; i++) tick();
        check_val("t4_held_on", bullet1_on, 1);
        check_val("t4_held_y", bullet1_y, 314 - 49 * SPD);
        keycode = '0;
        for (int i = 0; i < 40; i++) tick();
        check_val("t4_gone", bullet1_on, 0);
        keycode = 32'h0000_2C00;
        tick();
        check_val("t4_refire", bullet1_on, 1);

        // game_over with bullet2 flying and a tank2 hit pending.
        do_reset();
        set_tanks(100, 200, 1, 300, 200, 1);
        keycode = 32'h0000_282C;
        tick();
        keycode = '0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (m_pend[1] && m_on[1] != 0) found = 1;
        end
        check_val("t5_setup", found, 1);
        game_over = 1'b1;
        keycode = 32'h0000_2C28;
        tick();
        check_val("t5_on2", bullet2_on, 0);
        check_val("t5_hit2", shot_hit2, 0);
        tick(); tick();
        game_over = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check_val("t5_no_fire1", bullet1_on, 0);
        check_val("t5_no_fire2", bullet2_on, 0);
        check_val("t5_no_pulse", hit2_cnt, 0);
        keycode = '0;
        tick();

        // Reset mid-flight with a pending hit.
        do_reset();
        set_tanks(100, 200, 1, 300, 200, 1);
        keycode = 32'h0000_282C;
        tick();
        keycode = '0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (m_pend[1]) found = 1;
        end
        check_val("t6_setup", found, 1);
        Reset = 1'b1;
        tick();
        check_val("t6_on1", bullet1_on, 0);
        check_val("t6_on2", bullet2_on, 0);
        check_val("t6_x2", bullet2_x, 0);
        check_val("t6_hit2", shot_hit2, 0);
        Reset = 1'b0;
        hit2_cnt = 0;
        for (int i = 0; i < 6; i++) tick();
        check_val("t6_late_pulse", hit2_cnt, 0);

        // Randomized play: tanks placed to line up often, random keys, game_over and resets.
        go_left = 0;
        for (int seg = 0; seg < 40; seg++) begin
            t1x = $urandom_range(0, 600);
            t1y = $urandom_range(0, 440);
            if ($urandom_range(0, 1) == 1) begin
                t2x = $urandom_range(0, 600);
                t2y = t1y + int'($urandom_range(0, 40)) - 20;
                if (t2y < 0) t2y = 0;
                if (t2y > 440) t2y = 440;
                set_tanks(t1x, t1y, (t2x > t1x) ? 1 : 3, t2x, t2y, (t2x > t1x) ? 3 : 1);
            end else begin
                t2y = $urandom_range(0, 440);
                t2x = t1x + int'($urandom_range(0, 40)) - 20;
                if (t2x < 0) t2x = 0;
                if (t2x > 600) t2x = 600;
                set_tanks(t1x, t1y, (t2y > t1y) ? 2 : 0, t2x, t2y, (t2y > t1y) ? 0 : 2);
            end
            if ($urandom_range(0, 3) == 0) tank1_dir = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) tank2_dir = 2'($urandom_range(0, 3));
            for (int f = 0; f < 60; f++) begin
                kc = $urandom;
                if ($urandom_range(0, 2) == 0) kc[8 * $urandom_range(0, 3) +: 8] = K1;
                if ($urandom_range(0, 2) == 0) kc[8 * $urandom_range(0, 3) +: 8] = K2;
                keycode = kc;
                if (go_left > 0) go_left--;
                else if ($urandom_range(0, 60) == 0) go_left = $urandom_range(1, 4);
                game_over = (go_left > 0);
                Reset = ($urandom_range(0, 250) == 0);
                tick();
            end
        end
        Reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
